// File: rtl/grant_lock_ctrl_pkg.sv
// arb_pkg: shared widths and FSM encoding for the arbiter ownership stage.
package arb_pkg;
    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
endpackage

// File: rtl/grant_lock_ctrl_if.sv
// grant_lock_ctrl_if: request/grant inputs and owner-lock outputs of the ownership stage.
interface grant_lock_ctrl_if #(
    parameter int N     = arb_pkg::N,
    parameter int IDX_W = arb_pkg::IDX_W
);
    logic [N-1:0]     req;
    logic [N-1:0]     grant_in;
    logic             done;
    logic [N-1:0]     owner_grant;
    logic [IDX_W-1:0] owner_idx;
    logic             owner_valid;
    logic             timeout_err;
    modport master (output req, grant_in, done, input owner_grant, owner_idx, owner_valid, timeout_err);
    modport slave  (input req, grant_in, done, output owner_grant, owner_idx, owner_valid, timeout_err);
endinterface

// File: rtl/grant_lock_ctrl_onehot_idx_enc.sv
// onehot_idx_enc: one-hot to binary encoder; on illegal multi-hot input the highest set bit wins.
module onehot_idx_enc #(
    parameter int N     = arb_pkg::N,
    parameter int IDX_W = arb_pkg::IDX_W
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx
);
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
    end
endmodule

// File: rtl/grant_lock_ctrl.sv
// grant_lock_ctrl: holds the arbiter grant as a registered bus-owner lock until
// done, request drop or timeout, with one dead turnaround cycle after each release.
module grant_lock_ctrl #(
    parameter int N       = arb_pkg::N,
    parameter int IDX_W   = arb_pkg::IDX_W,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst_n,
    grant_lock_ctrl_if.slave bus
);
    import arb_pkg::*;

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]     r_grant, w_grant_nxt, w_clean;
    logic [IDX_W-1:0] r_idx, w_idx_nxt, w_enc;
    logic             r_valid, w_valid_nxt, r_terr, w_terr_nxt;
    logic             w_busy, w_lock, w_hold, w_owner_req, w_to, w_rel;

    onehot_idx_enc #(.N(N), .IDX_W(IDX_W)) u_enc (.i_vec(bus.grant_in), .o_idx(w_enc));

    // Illegal multi-hot grants collapse to the highest set bit
    assign w_clean     = N'(1) << w_enc;
    assign w_busy      = r_state == BUSY;
    assign w_owner_req = |(bus.req & r_grant);
    assign w_to        = (TIMEOUT != 0) && (r_cnt == LP_LIMIT);
    assign w_rel       = bus.done || !w_owner_req || w_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (|bus.grant_in ? BUSY : IDLE) :
                 w_busy            ? (w_rel ? RELEASE : BUSY)      : IDLE;
    end

    always_comb begin
        w_lock      = (r_state == IDLE) && |bus.grant_in;
        w_hold      = w_busy && !w_rel;
        w_grant_nxt = w_lock ? w_clean : w_hold ? r_grant : '0;
        w_idx_nxt   = w_lock ? w_enc   : w_hold ? r_idx   : '0;
        w_valid_nxt = w_lock || w_hold;
        w_terr_nxt  = w_busy && w_to && !bus.done && w_owner_req;
        w_cnt_nxt   = w_lock ? '0 : (w_busy && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_grant <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    assign bus.owner_grant = r_grant;
    assign bus.owner_idx   = r_idx;
    assign bus.owner_valid = r_valid;
    assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_grant_lock_ctrl.sv
// tb_grant_lock_ctrl: directed plus random stimulus checked against a cycle-level ownership model.
module tb_grant_lock_ctrl;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model: current owner (-1 = none), cycles held so far, and pending turnaround
    int   m_owner = -1;
    int   m_held = 0;
    bit   m_gap = 1'b0;
    bit   m_terr = 1'b0;

    grant_lock_ctrl_if bus ();
    grant_lock_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant"}, 32'(bus.owner_grant), m_owner < 0 ? 32'd0 : 32'd1 << m_owner);
        chk({tag, ".idx"},   32'(bus.owner_idx),   m_owner < 0 ? 32'd0 : 32'(m_owner));
        chk({tag, ".valid"}, 32'(bus.owner_valid), 32'(m_owner >= 0));
        chk({tag, ".terr"},  32'(bus.timeout_err), 32'(m_terr));
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 1'b0;
        m_terr  = 1'b0;
    endtask

    task automatic step(input string tag, input logic [7:0] r, input logic [7:0] g, input logic d);
        bit tmo, drop;
        bus.req = r;
        bus.grant_in = g;
        bus.done = d;
        @(posedge clk);
        m_terr = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            drop = !r[m_owner];
            tmo  = (TMO != 0) && (m_held >= TMO);
            if (d || drop || tmo) begin
                m_terr  = tmo && !d && !drop;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (g != 0) begin
            m_owner = top_bit(g);
            m_held  = 0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] r, g;
        bus.req = '0;
        bus.grant_in = '0;
        bus.done = 1'b0;
        #2;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held");
        rst_n = 1'b1;

        step("lock5",      8'h20, 8'h20, 1'b0);
        step("hold5",      8'ha0, 8'h80, 1'b0);
        step("hold5b",     8'ha0, 8'h80, 1'b0);
        step("done_rel",   8'ha0, 8'h80, 1'b1);
        step("gap_idle",   8'ha0, 8'h80, 1'b0);
        step("lock7",      8'ha0, 8'h80, 1'b0);
        step("drop7",      8'h00, 8'h00, 1'b0);
        step("gap7",       8'h00, 8'h00, 1'b0);

        step("lock2",      8'h04, 8'h04, 1'b0);
        for (int i = 0; i < TMO; i++) step("tmo_hold", 8'h04, 8'h00, 1'b0);
        step("tmo_gap",    8'h04, 8'h00, 1'b0);
        step("relock2",    8'h04, 8'h04, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step("sim_hold", 8'h04, 8'h00, 1'b0);
        step("sim_done",   8'h04, 8'h00, 1'b1);
        step("sim_gap",    8'h00, 8'h00, 1'b0);

        step("lock0",      8'h01, 8'h01, 1'b0);
        step("drop0",      8'h00, 8'h00, 1'b0);
        step("drop_gap",   8'h44, 8'h44, 1'b0);
        step("illegal",    8'h44, 8'h44, 1'b0);
        step("ill_hold",   8'h44, 8'h00, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_mid");
        #1;
        rst_n = 1'b1;
        step("post_rst",   8'h08, 8'h08, 1'b0);

        for (int n = 0; n < 400; n++) begin
            r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            g = r == 0 ? 8'h00 : ($urandom_range(0, 9) == 0 ? r : 8'h01 << top_bit(r));
            step("rand", r, g, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/grant_lock_ctrl.md
# grant_lock_ctrl

Downstream ownership stage for the 8-input fixed-priority arbiter. It samples the arbiter's one-hot grant vector and holds that grant as a registered bus-owner selection until the owner signals completion, drops its request, or hits a cycle timeout. It also presents the owner's binary index. This turns the purely combinational arbiter decision into a stable, transaction-length lock for the shared resource.

## Interface
Parameters:
- N, 8, number of requesters; must match the arbiter width.
- IDX_W, 3, width of the owner index (clog2(N)).
- TIMEOUT, 255, maximum cycles an owner may hold the lock. 0 disables the timeout. Range 0..255.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, N, raw request vector, the same vector that feeds the arbiter.
- grant_in, input, N, one-hot grant from the arbiter; all zeros when nothing is requested.
- done, input, 1, single-cycle pulse from the current owner marking end of transaction.
- owner_grant, output, N, registered one-hot lock; all zeros when unlocked.
- owner_idx, output, IDX_W, binary index of the set bit of owner_grant; 0 when unlocked.
- owner_valid, output, 1, high while a lock is held.
- timeout_err, output, 1, single-cycle pulse when a lock is force-released by timeout.

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- **IDLE**
  - If grant_in is nonzero, latch it into owner_grant, set owner_valid, clear the hold counter, and go to BUSY.
  - If grant_in has more than one bit set (illegal), keep only the highest set bit, consistent with the arbiter priority.
- **BUSY**
  - owner_grant and owner_idx are frozen; grant_in is ignored.
  - The counter increments each cycle, saturating at 8 bits.
  - Release causes, checked each cycle:
    - done = 1;
    - req[owner_idx] = 0 (owner abandoned its request);
    - counter == TIMEOUT-1 with TIMEOUT ≠ 0.
  - Any release cause moves the FSM to RELEASE and clears owner_grant, owner_idx and owner_valid.
  - timeout_err pulses only when the timeout is the sole cause.
- **RELEASE**
  - One dead cycle with all owner outputs zero; this guarantees a bus turnaround.
  - Always goes to IDLE.
- **Simultaneous events:** if done coincides with the timeout or with the request drop, treat it as a normal release; no timeout_err.
- done asserted in IDLE or RELEASE is ignored.
- **Reset:** asserting rst_n low at any time, including mid-BUSY, forces IDLE immediately and zeros every output and the counter, without waiting for a clock edge.

## Timing
- Reset values: owner_grant = 0, owner_idx = 0, owner_valid = 0, timeout_err = 0, state = IDLE.
- Lock latency: grant_in sampled at edge k in IDLE gives owner outputs valid after edge k. They are registered, with no combinational path from grant_in to any output.
- Release: a cause seen at edge k in BUSY clears the outputs after edge k (state RELEASE). Edge k+1 returns to IDLE, and edge k+2 is the earliest new lock. The minimum owner-to-owner gap is therefore 2 cycles with owner_valid low.
- Maximum hold: owner_valid stays high for at most TIMEOUT cycles. timeout_err is high for exactly the cycle after the forcing edge, coincident with RELEASE.
- All outputs are driven directly from flops.

## Structure
- Shared package arb_pkg holds:
  - the N and IDX_W constants;
  - the FSM state enum (IDLE, BUSY, RELEASE);
  - the counter width constant CNT_W = 8.
- One natural sub-module: onehot_idx_enc, a combinational N-bit one-hot to IDX_W-bit binary encoder with highest-bit priority for illegal inputs. It is used for both owner_idx and the illegal-vector cleanup.
- Everything else lives in the top module: the FSM, the counter and the output registers.

## Test plan
- **Basic lock:** reset, then grant_in = 8'b0010_0000 for one cycle in IDLE. Expect owner_grant = 8'b0010_0000, owner_idx = 5 and owner_valid = 1 on the next cycle, held while grant_in changes to 8'b1000_0000.
- **Done release:** while locked to index 5, pulse done. Expect outputs zero for 2 cycles (RELEASE, IDLE), then grant_in = 8'b1000_0000 is latched with owner_idx = 7.
- **Timeout:** TIMEOUT = 4, lock index 2 and never pulse done. Expect owner_valid high for exactly 4 cycles, then a one-cycle timeout_err pulse with outputs cleared.
- **Simultaneous done and timeout:** TIMEOUT = 4, pulse done on the 4th BUSY cycle. Expect a release with timeout_err = 0.
- **Request drop:** lock index 0, deassert req[0] with no done. Expect release on the next edge with no timeout_err. Then feed illegal grant_in = 8'b0100_0100 and expect owner_idx = 6.
- **Async reset:** assert rst_n low mid-BUSY between clock edges. Expect all outputs zero immediately; after deassertion, IDLE accepts a new grant on the first edge.
